// File: rtl/miner_pkg.sv
// Shared mining definitions: digest/nonce widths, default lane count and the
// serializer state encoding used by the hit collector.
package miner_pkg;

    localparam int DIGEST_W      = 256;
    localparam int NONCE_W       = 32;
    localparam int DEFAULT_LANES = 8;

    typedef logic [DIGEST_W-1:0] digest_t;
    typedef logic [NONCE_W-1:0]  nonce_t;

    // IDLE: no hits pending, a new batch may be accepted.
    // DRAIN: hit mask non-zero, winning lanes are being pushed to the FIFO.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } collect_state_t;

endpackage

// File: rtl/hit_fifo.sv
// Show-ahead FIFO for winning nonces. pop_data is valid whenever empty is low.
// A push on a full FIFO is accepted only together with a pop on the same edge.
module hit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; emptiness is tracked
        // by count and pop_data is forced to zero while empty.
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/hash_hit_collect.sv
// Compares a batch of LANES digests against a target, then serializes the
// winning lanes (lowest index first) into a show-ahead nonce FIFO.
module hash_hit_collect
    import miner_pkg::*;
#(
    parameter  int LANES      = DEFAULT_LANES,
    parameter  int FIFO_DEPTH = 4,
    localparam int LANE_W     = $clog2(LANES),
    localparam int BASE_W     = NONCE_W - LANE_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BASE_W-1:0]         in_nonce_base,
    input  logic [LANES*DIGEST_W-1:0] in_digest,
    input  logic [DIGEST_W-1:0]       target,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NONCE_W-1:0]        out_nonce,
    output logic [31:0]               hit_count,
    output logic [31:0]               batch_count
);

    collect_state_t    state;
    logic [LANES-1:0]  hit_mask;
    logic [BASE_W-1:0] base_q;
    logic [LANES-1:0]  lane_hit;
    logic [LANES-1:0]  cleared_mask;
    logic [LANE_W-1:0] sel_lane;
    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    nonce_t            push_nonce;

    assign in_ready     = (state == IDLE);
    assign accept       = in_valid && in_ready;
    assign out_valid    = !fifo_empty;
    assign pop          = out_valid && out_ready;
    assign push         = (state == DRAIN) && (!fifo_full || pop);
    assign cleared_mask = hit_mask & (hit_mask - LANES'(1));
    assign push_nonce   = {sel_lane, base_q};

    // Per-lane strict less-than comparators; equality with target is a miss.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        lane_hit = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_hit[i] = digest_t'(in_digest[i*DIGEST_W +: DIGEST_W]) < target;
        end
    end

    // Priority encoder: scanning downward lets the lowest set lane win.
    always_comb begin
        sel_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (hit_mask[i]) sel_lane = LANE_W'(i);
        end
    end

    // Serializer FSM with hit mask, nonce base and the two event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hit_mask    <= '0;
            base_q      <= '0;
            hit_count   <= '0;
            batch_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hit_mask    <= lane_hit;
                        base_q      <= in_nonce_base;
                        batch_count <= batch_count + 32'd1;
                        state       <= (|lane_hit) ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (push) begin
                        hit_mask  <= cleared_mask;
                        hit_count <= hit_count + 32'd1;
                        if (cleared_mask == '0) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    hit_fifo #(
        .WIDTH (NONCE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_nonce),
        .pop       (pop),
        .pop_data  (out_nonce),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_hash_hit_collect.sv
// Bench for hash_hit_collect: a queue-based model (pending hits + FIFO contents)
// checked against the DUT every cycle, plus directed tests with literal values.
module tb_hash_hit_collect;

    localparam int LANES  = 8;
    localparam int DEPTH  = 4;
    localparam int BASE_W = 29;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [BASE_W-1:0]  in_nonce_base;
    logic [LANES*256-1:0] in_digest;
    logic [255:0]       target;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_nonce;
    logic [31:0]        hit_count;
    logic [31:0]        batch_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // model state
    logic [31:0] m_fifo[$];
    logic [31:0] m_pend[$];
    logic [31:0] m_hits    = 0;
    logic [31:0] m_batches = 0;
    bit m_pop, m_push, m_acc;

    always #5 clk = ~clk;

    hash_hit_collect #(.LANES(LANES), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_nonce_base (in_nonce_base),
        .in_digest     (in_digest),
        .target        (target),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_nonce     (out_nonce),
        .hit_count     (hit_count),
        .batch_count   (batch_count)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending winning nonces drain into a DEPTH-entry FIFO.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_fifo.delete();
                m_pend.delete();
                m_hits    = 0;
                m_batches = 0;
            end else begin
                m_pop  = (m_fifo.size() > 0) && out_ready;
                m_push = (m_pend.size() > 0) && ((m_fifo.size() < DEPTH) || m_pop);
                m_acc  = in_valid && (m_pend.size() == 0);
                if (m_pop) void'(m_fifo.pop_front());
                if (m_push) begin
                    m_fifo.push_back(m_pend.pop_front());
                    m_hits = m_hits + 1;
                end
                if (m_acc) begin
                    m_batches = m_batches + 1;
                    for (int i = 0; i < LANES; i++) begin
                        if (in_digest[i*256 +: 256] < target)
                            m_pend.push_back({3'(i), in_nonce_base});
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("m_in_ready", in_ready, m_pend.size() == 0);
            check("m_out_valid", out_valid, m_fifo.size() > 0);
            check("m_out_nonce", out_nonce, (m_fifo.size() > 0) ? m_fifo[0] : 32'd0);
            check("m_hit_count", hit_count, m_hits);
            check("m_batch_count", batch_count, m_batches);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic set_lanes(input logic [7:0] sel, input logic [255:0] hv);
        for (int i = 0; i < LANES; i++)
            in_digest[i*256 +: 256] = sel[i] ? hv : {256{1'b1}};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one batch for exactly one edge; returns at the negedge after it.
    task automatic accept_batch();
        @(negedge clk);
        check("acc_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Collect nonces until lane 7; expect lanes first..7 in order.
    task automatic drain_order(input string name, input int first, input logic [BASE_W-1:0] base);
        int got;
        got = first;
        for (int cyc = 0; cyc < 40 && got < LANES; cyc++) begin
            if (out_valid) begin
                check(name, out_nonce, {3'(got), base});
                got++;
            end
            @(negedge clk);
        end
        check({name, "_count"}, got, LANES);
    endtask

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        in_nonce_base = '0;
        in_digest     = '1;
        target        = 256'd1 << 224;

        // Test 1: single hit on lane 5, two-cycle latency
        do_reset();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_nonce", out_nonce, 32'd0);
        out_ready     = 1'b1;
        target        = 256'd1 << 224;
        in_nonce_base = 29'h123;
        set_lanes(8'b0010_0000, 256'h1);
        accept_batch();
        check("t1_valid_edge0", out_valid, 1'b0);
        check("t1_ready_edge0", in_ready, 1'b0);
        @(negedge clk);
        check("t1_valid_edge1", out_valid, 1'b1);
        check("t1_nonce", out_nonce, 32'hA000_0123);
        check("t1_hit_count", hit_count, 32'd1);
        check("t1_batch_count", batch_count, 32'd1);
        check("t1_ready_edge1", in_ready, 1'b1);
        @(negedge clk);
        check("t1_valid_edge2", out_valid, 1'b0);

        // Test 2: all eight lanes hit under backpressure
        do_reset();
        in_nonce_base = 29'h0ABC_DEF;
        set_lanes(8'hFF, 256'h0);
        accept_batch();
        repeat (6) @(negedge clk);
        check("t2_ready_blocked", in_ready, 1'b0);
        check("t2_hits_full", hit_count, 32'd4);
        check("t2_head", out_nonce, 32'h00AB_CDEF);
        out_ready = 1'b1;
        drain_order("t2_order", 0, 29'h0ABC_DEF);
        check("t2_hit_count", hit_count, 32'd8);

        // Test 3: ten back-to-back zero-hit batches
        do_reset();
        set_lanes(8'h00, 256'h0);
        @(negedge clk);
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("t3_in_ready", in_ready, 1'b1);
            check("t3_out_valid", out_valid, 1'b0);
        end
        in_valid = 1'b0;
        check("t3_batch_count", batch_count, 32'd10);

        // Test 4: digest equal to target misses, target-1 hits
        do_reset();
        out_ready     = 1'b1;
        target        = {32'h0, 32'h1234_5678, 192'h0};
        in_nonce_base = 29'h4;
        set_lanes(8'h01, {32'h0, 32'h1234_5678, 192'h0});
        accept_batch();
        check("t4_eq_ready", in_ready, 1'b1);
        @(negedge clk);
        check("t4_eq_hits", hit_count, 32'd0);
        check("t4_eq_valid", out_valid, 1'b0);
        set_lanes(8'h01, {32'h0, 32'h1234_5677, {192{1'b1}}});
        accept_batch();
        @(negedge clk);
        check("t4_lt_valid", out_valid, 1'b1);
        check("t4_lt_nonce", out_nonce, 32'h0000_0004);
        check("t4_lt_hits", hit_count, 32'd1);

        // Test 5: reset mid-drain with 3 pending and 2 queued
        do_reset();
        target        = 256'd1 << 224;
        in_nonce_base = 29'h77;
        set_lanes(8'b0001_1111, 256'h0);
        accept_batch();
        repeat (2) @(negedge clk);
        check("t5_pre_hits", hit_count, 32'd2);
        check("t5_pre_ready", in_ready, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 1'b0);
        check("t5_rst_ready", in_ready, 1'b1);
        check("t5_rst_nonce", out_nonce, 32'd0);
        check("t5_rst_hits", hit_count, 32'd0);
        check("t5_rst_batches", batch_count, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t5_no_stale", out_valid, 1'b0);
        end
        check("t5_post_hits", hit_count, 32'd0);

        // Test 6: simultaneous push and pop on a full FIFO
        do_reset();
        in_nonce_base = 29'h55;
        set_lanes(8'hFF, 256'h0);
        accept_batch();
        repeat (4) @(negedge clk);
        check("t6_full_hits", hit_count, 32'd4);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t6_pushpop_hits", hit_count, 32'd5);
        check("t6_pushpop_valid", out_valid, 1'b1);
        check("t6_pushpop_head", out_nonce, 32'h2000_0055);
        repeat (2) @(negedge clk);
        check("t6_still_full", hit_count, 32'd5);
        out_ready = 1'b1;
        drain_order("t6_order", 1, 29'h55);
        check("t6_hit_count", hit_count, 32'd8);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
